mesh_traffic_ctrl: RTL and testbench

- Configuration and run sequencer for the 2x4 mesh NoC traffic test.
- Holds the per-PE task configuration for all 8 PEs, written over a simple register-write port, and drives the mesh's packed PE configuration buses.
- Sequences one test run: flush, then enable, then wait for every selected PE to report send and receive finish, then report done, abort or timeout.
- Sits between the test host/bench and the mesh top.

---
 rtl/mesh_traffic_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mesh_traffic_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_traffic_ctrl.sv
// Configuration store and run sequencer for the 2x4 mesh NoC traffic test.
// Optional watchdog enabled by defining MESH_TRAFFIC_CTRL_TIMEOUT_EN.
module mesh_traffic_ctrl #(
  parameter int              FLUSH_CYCLES = 4,
  parameter int              CNT_W        = 16,
  parameter logic [CNT_W-1:0] TIMEOUT     = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_addr,
  input  logic [31:0]       cfg_wdata,
  input  logic [7:0]        run_mask,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        pe_task_send_finish_flag,
  input  logic [7:0]        pe_task_receive_finish_flag,
  output logic [7:0]        pe_enable,
  output logic [7:0]        pe_dbg_mode_wire,
  output logic [23:0]       pe_send_num_wire,
  output logic [23:0]       pe_receive_num_wire,
  output logic [31:0]       pe_rate_wire,
  output logic [31:0]       pe_mode_wire,
  output logic [191:0]      pe_dst_seq_wire,
  output logic [7:0]        pe_flush_wire,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  run_cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_RUN,
    S_DONE,
    S_ERR
  } state_t;

  state_t state, state_next;

  logic [7:0]  mask;
  logic [3:0]  flush_cnt;
  logic        cfg_open;
  logic        complete;
  logic        timeout_hit;

  logic [2:0]  send_num    [8];
  logic [2:0]  receive_num [8];
  logic [3:0]  rate        [8];
  logic [3:0]  mode        [8];
  logic        dbg_mode    [8];
  logic [23:0] dst_seq     [8];

  assign cfg_open = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);

  // Flags seen in the first RUN cycle may be left over from a previous run.
  assign complete = (run_cycles != '0)
                 && ((pe_task_send_finish_flag    & mask) == mask)
                 && ((pe_task_receive_finish_flag & mask) == mask);

`ifdef MESH_TRAFFIC_CTRL_TIMEOUT_EN
  assign timeout_hit = (run_cycles == TIMEOUT);
  assign timeout_err = (state == S_ERR);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  logic unused_wdata;
  assign unused_wdata = ^cfg_wdata[31:24];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE, S_DONE, S_ERR: if (start) state_next = S_FLUSH;
        S_FLUSH: if (flush_cnt == 4'd1) state_next = (mask == '0) ? S_DONE : S_RUN;
        S_RUN: begin
          if (complete)         state_next = S_DONE;
          else if (timeout_hit) state_next = S_ERR;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask       <= '0;
      flush_cnt  <= '0;
      run_cycles <= '0;
    end else if (!abort) begin
      if (cfg_open && start) begin
        mask       <= run_mask;
        run_cycles <= '0;
        flush_cnt  <= 4'(FLUSH_CYCLES);
      end
      if (state == S_FLUSH) flush_cnt <= flush_cnt - 4'd1;
      if (state == S_RUN && run_cycles != '1) run_cycles <= run_cycles + 1'b1;
    end
  end

  // NOTE: the config arrays are small flop banks, so they take the async reset like any other state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        send_num[i]    <= '0;
        receive_num[i] <= '0;
        rate[i]        <= '0;
        mode[i]        <= '0;
        dbg_mode[i]    <= 1'b0;
        dst_seq[i]     <= '0;
      end
    end else if (cfg_we && cfg_open) begin
      if (cfg_addr[3]) begin
        dst_seq[cfg_addr[2:0]] <= cfg_wdata[23:0];
      end else begin
        send_num[cfg_addr[2:0]]    <= cfg_wdata[2:0];
        receive_num[cfg_addr[2:0]] <= cfg_wdata[6:4];
        rate[cfg_addr[2:0]]        <= cfg_wdata[11:8];
        mode[cfg_addr[2:0]]        <= cfg_wdata[15:12];
        dbg_mode[cfg_addr[2:0]]    <= cfg_wdata[16];
      end
    end
  end

  always_comb begin
    pe_send_num_wire    = '0;
    pe_receive_num_wire = '0;
    pe_rate_wire        = '0;
    pe_mode_wire        = '0;
    pe_dbg_mode_wire    = '0;
    pe_dst_seq_wire     = '0;
    for (int i = 0; i < 8; i++) begin
      pe_send_num_wire[3*i +: 3]    = send_num[i];
      pe_receive_num_wire[3*i +: 3] = receive_num[i];
      pe_rate_wire[4*i +: 4]        = rate[i];
      pe_mode_wire[4*i +: 4]        = mode[i];
      pe_dbg_mode_wire[i]           = dbg_mode[i];
      pe_dst_seq_wire[24*i +: 24]   = dst_seq[i];
    end
  end

  assign pe_enable     = (state == S_RUN)   ? mask : '0;
  assign pe_flush_wire = (state == S_FLUSH) ? mask : '0;
  assign busy          = (state == S_FLUSH) || (state == S_RUN);
  assign done          = (state == S_DONE);

endmodule

// File: tb/tb_mesh_traffic_ctrl.sv
// Directed self-checking bench for mesh_traffic_ctrl: config layout, runs,
// masking, write lockout, abort, async reset and the watchdog / no-watchdog build.
module tb_mesh_traffic_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_we;
  logic [3:0]   cfg_addr;
  logic [31:0]  cfg_wdata;
  logic [7:0]   run_mask;
  logic         start;
  logic         abort;
  logic [7:0]   send_flag;
  logic [7:0]   recv_flag;
  logic [7:0]   pe_enable;
  logic [7:0]   pe_dbg_mode_wire;
  logic [23:0]  pe_send_num_wire;
  logic [23:0]  pe_receive_num_wire;
  logic [31:0]  pe_rate_wire;
  logic [31:0]  pe_mode_wire;
  logic [191:0] pe_dst_seq_wire;
  logic [7:0]   pe_flush_wire;
  logic         busy;
  logic         done;
  logic         timeout_err;
  logic [15:0]  run_cycles;

  int errors = 0;
  int checks = 0;

  mesh_traffic_ctrl #(
    .FLUSH_CYCLES(4),
    .CNT_W(16),
    .TIMEOUT(16'd20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cfg_we(cfg_we),
    .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata),
    .run_mask(run_mask),
    .start(start),
    .abort(abort),
    .pe_task_send_finish_flag(send_flag),
    .pe_task_receive_finish_flag(recv_flag),
    .pe_enable(pe_enable),
    .pe_dbg_mode_wire(pe_dbg_mode_wire),
    .pe_send_num_wire(pe_send_num_wire),
    .pe_receive_num_wire(pe_receive_num_wire),
    .pe_rate_wire(pe_rate_wire),
    .pe_mode_wire(pe_mode_wire),
    .pe_dst_seq_wire(pe_dst_seq_wire),
    .pe_flush_wire(pe_flush_wire),
    .busy(busy),
    .done(done),
    .timeout_err(timeout_err),
    .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [3:0] addr, input logic [31:0] data);
    cfg_we    = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = data;
    tick();
    cfg_we    = 1'b0;
  endtask

  // Issue start and step through the four FLUSH cycles, checking each one.
  task automatic start_and_flush(input logic [7:0] m);
    run_mask = m;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("flush_wire", pe_flush_wire, m);
      check("flush_en", pe_enable, 8'h00);
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    run_mask = '0; start = 1'b0; abort = 1'b0; send_flag = '0; recv_flag = '0;
    tick();
    check("rst_status", {busy, done, timeout_err}, 3'b000);
    check("rst_enable", pe_enable, 8'h00);
    check("rst_cycles", run_cycles, 16'd0);
    check("rst_dst", pe_dst_seq_wire, '0);
    rst = 1'b0;
    tick();

    // Config layout for PE 3.
    cfg_write(4'h3, 32'h0001_5A31);
    cfg_write(4'hB, 32'h00AB_CDEF);
    check("send_num3", pe_send_num_wire[11:9], 3'd1);
    check("recv_num3", pe_receive_num_wire[11:9], 3'd3);
    check("rate3", pe_rate_wire[15:12], 4'hA);
    check("mode3", pe_mode_wire[15:12], 4'h5);
    check("dbg3", pe_dbg_mode_wire, 8'h08);
    check("dst3", pe_dst_seq_wire[95:72], 24'hABCDEF);
    check("dst0", pe_dst_seq_wire[23:0], 24'h0);

    // Abort has priority over start.
    run_mask = 8'hFF; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("abort_prio", {busy, done, timeout_err}, 3'b000);

    // Full run with a config write in FLUSH and start+write in RUN.
    run_mask = 8'hFF;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("full_flush", pe_flush_wire, 8'hFF);
      check("full_flush_en", pe_enable, 8'h00);
      if (i == 1) begin cfg_we = 1'b1; cfg_addr = 4'h3; cfg_wdata = 32'h0; end
      tick();
      cfg_we = 1'b0;
    end
    check("flush_lock", pe_send_num_wire[11:9], 3'd1);
    check("run_enable", pe_enable, 8'hFF);
    check("run_flush", pe_flush_wire, 8'h00);
    check("run_status", {busy, done, timeout_err}, 3'b100);
    for (int c = 0; c < 10; c++) begin
      if (c == 2) begin start = 1'b1; cfg_we = 1'b1; cfg_addr = 4'hB; cfg_wdata = 32'h0; end
      tick();
      start = 1'b0; cfg_we = 1'b0;
    end
    check("run_cyc10", run_cycles, 16'd10);
    check("run_lock", pe_dst_seq_wire[95:72], 24'hABCDEF);
    send_flag = 8'hFF; recv_flag = 8'hFF;
    tick();
    check("full_status", {busy, done, timeout_err}, 3'b010);
    check("full_cycles", run_cycles, 16'd11);
    check("full_enable", pe_enable, 8'h00);
    tick();
    check("done_frozen", run_cycles, 16'd11);

    // Partial mask with stale flags already high in RUN cycle 0.
    send_flag = 8'h00; recv_flag = 8'h00;
    start_and_flush(8'h05);
    send_flag = 8'hF5; recv_flag = 8'h05;
    check("part_enable", pe_enable, 8'h05);
    tick();
    check("stale_ignored", {busy, done}, 2'b10);
    check("part_enable1", pe_enable, 8'h05);
    tick();
    check("part_status", {busy, done, timeout_err}, 3'b010);
    check("part_cycles", run_cycles, 16'd2);
    send_flag = 8'h00; recv_flag = 8'h00;

    // Empty mask skips RUN.
    start_and_flush(8'h00);
    check("zero_status", {busy, done}, 2'b01);
    check("zero_cycles", run_cycles, 16'd0);

    // Abort in RUN cycle 5.
    start_and_flush(8'hFF);
    for (int c = 0; c < 5; c++) tick();
    check("pre_abort_cyc", run_cycles, 16'd5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_status", {busy, done, timeout_err}, 3'b000);
    check("abort_enable", pe_enable, 8'h00);
    tick();
    check("abort_cycles", run_cycles, 16'd5);
    check("abort_cfg", pe_dst_seq_wire[95:72], 24'hABCDEF);

    // Watchdog build trips after 20 RUN cycles; default build keeps waiting.
    start_and_flush(8'hFF);
`ifdef MESH_TRAFFIC_CTRL_TIMEOUT_EN
    for (int c = 0; c < 21; c++) tick();
    check("timeout_status", {busy, done, timeout_err}, 3'b001);
    check("timeout_enable", pe_enable, 8'h00);
`else
    for (int c = 0; c < 100; c++) tick();
    check("no_timeout", {busy, done, timeout_err}, 3'b100);
    check("no_timeout_cyc", run_cycles, 16'd100);
`endif
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Asynchronous reset in the middle of a run.
    start_and_flush(8'hFF);
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_enable", pe_enable, 8'h00);
    check("arst_status", {busy, done, timeout_err}, 3'b000);
    check("arst_cycles", run_cycles, 16'd0);
    check("arst_cfg", pe_dst_seq_wire, '0);
    tick();
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
